// File: rtl/lau_pkg.sv
// lau_pkg: shared types for the arithmetic unit library
//   speed_e          : adder implementation choice (SLOW ripple, FAST lookahead-friendly)
//   sub_iter_state_e : control states of the digit-serial subtractor
package lau_pkg;
    typedef enum logic [0:0] {SLOW, FAST} speed_e;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_iter_state_e;
endpackage

// File: rtl/AddCfast.sv
// AddCfast: combinational adder slice, {CO,S} = A + B + CI
//   A, B : width-bit addends
//   CI   : carry in
//   S    : width-bit sum
//   CO   : carry out
module AddCfast
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    output logic [width-1:0] S,
    output logic             CO
);
    generate
        if (speed == FAST) begin : g_fast
            // Flat add so synthesis is free to build a lookahead structure.
            assign {CO, S} = {1'b0, A} + {1'b0, B} + {{width{1'b0}}, CI};
        end else begin : g_slow
            logic [width:0] c;
            assign c[0] = CI;
            for (genvar i = 0; i < width; i++) begin : g_bit
                assign S[i]   = A[i] ^ B[i] ^ c[i];
                assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
            end
            assign CO = c[width];
        end
    endgenerate
endmodule

// File: rtl/sub_c_iter.sv
// sub_c_iter: digit-serial subtractor {BO,D} = A - B - BI behind valid/ready
//   clk_i, rst_ni    : clock, async active-low reset
//   valid_i, ready_o : operand handshake (A, B, BI sampled on accept)
//   valid_o, ready_i : result handshake (D, BO, Z held until taken)
//   D                : A - B - BI mod 2^width
//   BO               : borrow out, 1 iff A < B + BI
//   Z                : D == 0
module sub_c_iter
    import lau_pkg::*;
#(
    parameter int     width = 32,
    parameter int     digit = 8,
    parameter speed_e speed = FAST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             BI,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [width-1:0] D,
    output logic             BO,
    output logic             Z
);
    localparam int ndig = width / digit;
    localparam int cw   = ndig > 1 ? $clog2(ndig) : 1;

    generate
        if (width % digit != 0) begin : g_chk
            $fatal(1, "sub_c_iter: width must be a multiple of digit");
        end
    endgenerate

    sub_iter_state_e  state_q, state_d;
    logic [width-1:0] a_q, b_q, d_q, d_nx;
    logic [cw-1:0]    cnt_q;
    logic [digit-1:0] s;
    logic             carry_q, co, bo_q, z_q, last;

    assign last = cnt_q == cw'(ndig - 1);

    // Subtraction as A + ~B + ~BI; the inverted borrow rides in the carry register.
    AddCfast #(.width(digit), .speed(speed)) u_add (
        .A (a_q[cnt_q*digit +: digit]),
        .B (~b_q[cnt_q*digit +: digit]),
        .CI(carry_q),
        .S (s),
        .CO(co)
    );

    // Result word with the current digit merged in, so Z sees the final digit.
    always_comb begin
        d_nx = d_q;
        d_nx[cnt_q*digit +: digit] = s;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = valid_i ? BUSY : IDLE;
            BUSY:    state_d = last ? DONE : BUSY;
            DONE:    state_d = ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = state_q == IDLE;
        valid_o = state_q == DONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            bo_q    <= 1'b0;
            z_q     <= 1'b0;
        end else if (state_q == IDLE && valid_i) begin
            a_q     <= A;
            b_q     <= B;
            d_q     <= '0;
            cnt_q   <= '0;
            carry_q <= ~BI;
        end else if (state_q == BUSY) begin
            d_q     <= d_nx;
            carry_q <= co;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                bo_q <= ~co;
                z_q  <= d_nx == '0;
            end
        end

    assign D  = d_q;
    assign BO = bo_q;
    assign Z  = z_q;
endmodule
